// File: rtl/axi3_identity_device_if.sv
// AXI3 write and read channel bundles for the identity device.
interface axi3_wr_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]    awid;
    logic [ADDR_WIDTH-1:0]  awaddr;
    logic [3:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;

    logic [ID_WIDTH-1:0]    wid;
    logic [BUS_WIDTH-1:0]   wdata;
    logic [BUS_WIDTH/8-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;

    logic [ID_WIDTH-1:0]    bid;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

interface axi3_rd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [BUS_WIDTH-1:0]  rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi3_identity_device.sv
// AXI3 slave model: write bursts assemble into one line, reads return their own address.
// Read path compiled in only when IDENTITY_DEVICE_RD_EN is defined; otherwise tied off.
module axi3_identity_device #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    axi3_wr_if.slave              axi3_wr_if,
    axi3_rd_if.slave              axi3_rd_if,
    output logic [LINE_WIDTH-1:0] line_recv,
    output logic                  line_recv_vld
);
    localparam int BEATS = LINE_WIDTH / DATA_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    wr_state_t             wr_state;
    logic [IDX_W-1:0]      idx;
    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_upd;
    logic [DATA_WIDTH-1:0] wmasked;
    logic                  awready;
    logic                  wready;
    logic                  bvalid;
    logic [ID_WIDTH-1:0]   bid;

    assign axi3_wr_if.awready = awready;
    assign axi3_wr_if.wready  = wready;
    assign axi3_wr_if.bvalid  = bvalid;
    assign axi3_wr_if.bid     = bid;
    assign axi3_wr_if.bresp   = 2'b00;

    logic unused_wr;
    assign unused_wr = ^{axi3_wr_if.awaddr, axi3_wr_if.awlen, axi3_wr_if.awsize,
                         axi3_wr_if.awburst, axi3_wr_if.wid};

    always_comb begin
        wmasked = '0;
        for (int unsigned k = 0; k < STRB_W; k++) begin
            if (axi3_wr_if.wstrb[k])
                wmasked[8*k +: 8] = axi3_wr_if.wdata[8*k +: 8];
        end
        line_upd = line_q;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (idx == IDX_W'(b))
                line_upd[b*DATA_WIDTH +: DATA_WIDTH] = wmasked;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state      <= W_IDLE;
            awready       <= 1'b0;
            wready        <= 1'b0;
            bvalid        <= 1'b0;
            bid           <= '0;
            idx           <= '0;
            line_q        <= '0;
            line_recv     <= '0;
            line_recv_vld <= 1'b0;
        end else begin
            line_recv_vld <= 1'b0;
            unique case (wr_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (axi3_wr_if.awvalid && awready) begin
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        bid      <= axi3_wr_if.awid;
                        idx      <= '0;
                        line_q   <= '0;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi3_wr_if.wvalid && wready) begin
                        line_q <= line_upd;
                        // over-length bursts wrap and overwrite earlier beats
                        idx    <= (idx == IDX_W'(BEATS - 1)) ? '0 : idx + 1'b1;
                        if (axi3_wr_if.wlast) begin
                            wready        <= 1'b0;
                            bvalid        <= 1'b1;
                            line_recv     <= line_upd;
                            line_recv_vld <= 1'b1;
                            wr_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi3_wr_if.bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

`ifdef IDENTITY_DEVICE_RD_EN
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    rd_state_t             rd_state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [3:0]            rd_len;
    logic [3:0]            rd_cnt;
    logic [3:0]            rd_next_cnt;
    logic [DATA_WIDTH-1:0] rd_next_data;
    logic                  arready;
    logic                  rvalid;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;

    assign axi3_rd_if.arready = arready;
    assign axi3_rd_if.rvalid  = rvalid;
    assign axi3_rd_if.rlast   = rlast;
    assign axi3_rd_if.rid     = rid;
    assign axi3_rd_if.rdata   = rdata;
    assign axi3_rd_if.rresp   = 2'b00;

    logic unused_rd;
    assign unused_rd = ^{axi3_rd_if.arsize, axi3_rd_if.arburst};

    always_comb begin
        rd_next_cnt  = rd_cnt + 4'd1;
        rd_next_data = DATA_WIDTH'(rd_addr + (ADDR_WIDTH'(rd_next_cnt) << 2));
    end

    // rdata/rlast are precomputed for the next beat so they stay registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
        end else begin
            unique case (rd_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (axi3_rd_if.arvalid && arready) begin
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rid      <= axi3_rd_if.arid;
                        rd_addr  <= axi3_rd_if.araddr;
                        rd_len   <= axi3_rd_if.arlen;
                        rd_cnt   <= '0;
                        rdata    <= DATA_WIDTH'(axi3_rd_if.araddr);
                        rlast    <= (axi3_rd_if.arlen == 4'd0);
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi3_rd_if.rready) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            rd_state <= R_IDLE;
                        end else begin
                            rd_cnt <= rd_next_cnt;
                            rdata  <= rd_next_data;
                            rlast  <= (rd_next_cnt == rd_len);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end
`else
    assign axi3_rd_if.arready = 1'b0;
    assign axi3_rd_if.rvalid  = 1'b0;
    assign axi3_rd_if.rlast   = 1'b0;
    assign axi3_rd_if.rid     = '0;
    assign axi3_rd_if.rdata   = '0;
    assign axi3_rd_if.rresp   = 2'b00;

    logic unused_rd;
    assign unused_rd = ^{axi3_rd_if.arid, axi3_rd_if.araddr, axi3_rd_if.arlen,
                         axi3_rd_if.arsize, axi3_rd_if.arburst, axi3_rd_if.arvalid,
                         axi3_rd_if.rready};
`endif

endmodule

// File: tb/tb_axi3_identity_device.sv
// Scoreboard bench for axi3_identity_device; read tests follow IDENTITY_DEVICE_RD_EN.
module tb_axi3_identity_device;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi3_wr_if #(.ADDR_WIDTH(32), .BUS_WIDTH(32), .ID_WIDTH(4)) wr_bus ();
    axi3_rd_if #(.ADDR_WIDTH(32), .BUS_WIDTH(32), .ID_WIDTH(4)) rd_bus ();

    logic [255:0] line_recv;
    logic         line_recv_vld;

    axi3_identity_device #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LINE_WIDTH(256),
        .ID_WIDTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .axi3_wr_if    (wr_bus),
        .axi3_rd_if    (rd_bus),
        .line_recv     (line_recv),
        .line_recv_vld (line_recv_vld)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] actual,
                            input logic [255:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    logic [255:0] exp_lines[$];
    logic [3:0]   exp_bids[$];
    logic [32:0]  exp_rbeats[$];
    logic [3:0]   exp_rid;
    logic [255:0] last_line;
    logic [31:0]  beat_data[16];
    logic [3:0]   beat_strb[16];

    // Monitors sample on the falling edge, away from the DUT's active edge.
    logic        prev_stall = 1'b0;
    logic [34:0] prev_r;
    always @(negedge clk) begin
        if (rst) begin
            if (line_recv_vld) begin
                if (exp_lines.size() == 0) check_eq("unexpected_line", 1, 0);
                else check_eq("line_recv", line_recv, exp_lines.pop_front());
            end
            if (wr_bus.bvalid && wr_bus.bready) begin
                if (exp_bids.size() == 0) check_eq("unexpected_b", 1, 0);
                else begin
                    check_eq("bid", wr_bus.bid, exp_bids.pop_front());
                    check_eq("bresp", wr_bus.bresp, 0);
                end
            end
            if (wr_bus.bvalid) check_eq("aw_blocked_in_resp", wr_bus.awready, 0);
            if (prev_stall)
                check_eq("r_stall_hold", {rd_bus.rvalid, rd_bus.rlast, rd_bus.rdata}, prev_r);
            if (rd_bus.rvalid && rd_bus.rready) begin
                if (exp_rbeats.size() == 0) check_eq("unexpected_r", 1, 0);
                else begin
                    logic [32:0] e;
                    e = exp_rbeats.pop_front();
                    check_eq("rdata", rd_bus.rdata, e[31:0]);
                    check_eq("rlast", rd_bus.rlast, e[32]);
                    check_eq("rid", rd_bus.rid, exp_rid);
                    check_eq("rresp", rd_bus.rresp, 0);
                end
            end
            prev_stall = rd_bus.rvalid && !rd_bus.rready;
            prev_r     = {rd_bus.rvalid, rd_bus.rlast, rd_bus.rdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic set_beats(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            beat_data[i] = base + 32'(i);
            beat_strb[i] = 4'hF;
        end
    endtask

    task automatic aw_phase(input logic [3:0] id, input int nbeats);
        int t;
        @(posedge clk);
        #1;
        wr_bus.awvalid = 1'b1;
        wr_bus.awid    = id;
        wr_bus.awlen   = 4'(nbeats - 1);
        wr_bus.awaddr  = 32'h0000_2000;
        wr_bus.awsize  = 3'd2;
        wr_bus.awburst = 2'd1;
        t = 0;
        @(posedge clk);
        while (!wr_bus.awready && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60) check_eq("aw_timeout", 1, 0);
        #1;
        wr_bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input int i, input bit last);
        int t;
        wr_bus.wvalid = 1'b1;
        wr_bus.wdata  = beat_data[i];
        wr_bus.wstrb  = beat_strb[i];
        wr_bus.wlast  = last;
        wr_bus.wid    = 4'hA;
        t = 0;
        @(posedge clk);
        while (!wr_bus.wready && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60) check_eq("w_timeout", 1, 0);
        #1;
        wr_bus.wvalid = 1'b0;
        wr_bus.wlast  = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input int nbeats);
        logic [255:0] exp;
        logic [31:0]  m;
        exp = '0;
        for (int i = 0; i < nbeats; i++) begin
            for (int k = 0; k < 4; k++)
                m[8*k +: 8] = beat_strb[i][k] ? beat_data[i][8*k +: 8] : 8'h00;
            exp[(i % 8)*32 +: 32] = m;
        end
        exp_lines.push_back(exp);
        exp_bids.push_back(id);
        last_line = exp;
        aw_phase(id, nbeats);
        for (int i = 0; i < nbeats; i++) w_beat(i, i == nbeats - 1);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((exp_lines.size() != 0 || exp_bids.size() != 0 || exp_rbeats.size() != 0
                || wr_bus.bvalid) && t < 200) begin
            @(posedge clk);
            t++;
        end
        check_eq(tag, t >= 200, 0);
    endtask

`ifdef IDENTITY_DEVICE_RD_EN
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input int nbeats, input bit toggle);
        int t;
        exp_rid = id;
        for (int i = 0; i < nbeats; i++)
            exp_rbeats.push_back({i == nbeats - 1, addr + 32'(4*i)});
        @(posedge clk);
        #1;
        rd_bus.arvalid = 1'b1;
        rd_bus.arid    = id;
        rd_bus.araddr  = addr;
        rd_bus.arlen   = 4'(nbeats - 1);
        rd_bus.arsize  = 3'd2;
        rd_bus.arburst = 2'd1;
        t = 0;
        @(posedge clk);
        while (!rd_bus.arready && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60) check_eq("ar_timeout", 1, 0);
        #1;
        rd_bus.arvalid = 1'b0;
        rd_bus.rready  = 1'b1;
        t = 0;
        while (exp_rbeats.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            if (toggle) rd_bus.rready = ~rd_bus.rready;
            t++;
        end
        if (t >= 100) check_eq("r_timeout", 1, 0);
        rd_bus.rready = 1'b0;
    endtask
`endif

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        wr_bus.awvalid = 1'b0; wr_bus.awid = '0; wr_bus.awaddr = '0; wr_bus.awlen = '0;
        wr_bus.awsize = '0; wr_bus.awburst = '0;
        wr_bus.wvalid = 1'b0; wr_bus.wid = '0; wr_bus.wdata = '0; wr_bus.wstrb = '0;
        wr_bus.wlast = 1'b0; wr_bus.bready = 1'b1;
        rd_bus.arvalid = 1'b0; rd_bus.arid = '0; rd_bus.araddr = '0; rd_bus.arlen = '0;
        rd_bus.arsize = '0; rd_bus.arburst = '0; rd_bus.rready = 1'b0;
        exp_rid = '0;
        last_line = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {wr_bus.awready, wr_bus.wready, wr_bus.bvalid, wr_bus.bid,
                 wr_bus.bresp, rd_bus.arready, rd_bus.rvalid, rd_bus.rid, rd_bus.rdata,
                 rd_bus.rresp, rd_bus.rlast, line_recv_vld}, '0);
        check_eq("reset_line", line_recv, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("awready_after_reset", wr_bus.awready, 1);

        // Basic line: beats 0..7, id 1
        set_beats(32'h0);
        write_burst(4'd1, 8);
        wait_drain("drain_basic");

        // Back-to-back bursts with bready held high
        set_beats(32'h1111_0000);
        write_burst(4'd2, 8);
        set_beats(32'hA5A5_0100);
        write_burst(4'd3, 8);
        wait_drain("drain_b2b");

        // Partial strobe on beat 0
        set_beats(32'h0000_0010);
        beat_data[0] = 32'hDEAD_BEEF;
        beat_strb[0] = 4'h3;
        beat_strb[5] = 4'b1010;
        write_burst(4'd4, 8);
        wait_drain("drain_strb");
        check_eq("strb_low_word", line_recv[31:0], 32'h0000_BEEF);

        // Over-length burst wraps onto beats 0 and 1; short burst leaves the rest zero
        set_beats(32'h7700_0000);
        write_burst(4'd5, 10);
        set_beats(32'h0BAD_0000);
        write_burst(4'd6, 1);
        wait_drain("drain_wrap");

        // Response stalled by bready
        wr_bus.bready = 1'b0;
        set_beats(32'h5000_0000);
        write_burst(4'd7, 8);
        repeat (5) @(posedge clk);
        #1;
        check_eq("bvalid_held", wr_bus.bvalid, 1);
        check_eq("bid_held", wr_bus.bid, 4'd7);
        wr_bus.bready = 1'b1;
        wait_drain("drain_bstall");

        // Reset mid-burst after three beats: no line, no response
        set_beats(32'hCAFE_0000);
        aw_phase(4'd8, 8);
        for (int i = 0; i < 3; i++) w_beat(i, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("abort_outputs", {wr_bus.awready, wr_bus.wready, wr_bus.bvalid, wr_bus.bid,
                 rd_bus.arready, rd_bus.rvalid, line_recv_vld}, '0);
        check_eq("abort_line", line_recv, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        last_line = '0;
        repeat (3) @(posedge clk);
        set_beats(32'h600D_0000);
        write_burst(4'd9, 8);
        wait_drain("drain_after_abort");

`ifdef IDENTITY_DEVICE_RD_EN
        read_burst(4'd3, 32'h0000_1000, 8, 1'b1);
        wait_drain("drain_rd_toggle");
        read_burst(4'd5, 32'hFFFF_FFFC, 2, 1'b0);
        read_burst(4'd6, 32'h0000_0040, 1, 1'b0);
        wait_drain("drain_rd_edge");
        fork
            read_burst(4'd2, 32'h0000_8000, 8, 1'b1);
            begin
                set_beats(32'h3300_0000);
                write_burst(4'd10, 8);
            end
        join
        wait_drain("drain_concurrent");
`else
        rd_bus.rready = 1'b1;
        fork
            begin
                @(posedge clk);
                #1;
                rd_bus.arvalid = 1'b1;
                rd_bus.araddr  = 32'h0000_1000;
                rd_bus.arlen   = 4'd7;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    check_eq("arready_tied", rd_bus.arready, 0);
                    check_eq("rvalid_tied", rd_bus.rvalid, 0);
                end
                check_eq("r_outputs_tied", {rd_bus.rlast, rd_bus.rid, rd_bus.rdata, rd_bus.rresp}, '0);
                rd_bus.arvalid = 1'b0;
            end
            begin
                set_beats(32'h4400_0000);
                write_burst(4'd11, 8);
            end
        join
        wait_drain("drain_tieoff");
`endif

        repeat (5) @(posedge clk);
        #1;
        check_eq("line_recv_holds", line_recv, last_line);
        check_eq("lines_left", exp_lines.size(), 0);
        check_eq("bids_left", exp_bids.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi3_identity_device.md
# axi3_identity_device

Simulation-side AXI3 slave model that stands in for memory behind a cache write buffer or other line-based master. Write bursts are assembled into one cache line, and each completed burst is reported on a one-cycle `line_recv_vld` strobe for a scoreboard to check. Read bursts are answered with "identity" data, where each beat returns its own byte address. Read and write channels run independently in the same clock domain.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: AXI address width.
- `DATA_WIDTH`, default 32: AXI data-beat width. Must be 32.
- `LINE_WIDTH`, default 256: assembled line width. `BEATS = LINE_WIDTH/DATA_WIDTH`.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset. Asynchronous, active-low (asserted at 0).
- `axi3_wr_if`, slave modport of `axi3_wr_if #(BUS_WIDTH)`, with these channels:
  - AW: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid`/`awready`.
  - W: `wid`, `wdata`, `wstrb`, `wlast`, `wvalid`/`wready`.
  - B: `bid`, `bresp`, `bvalid`/`bready`.
- `axi3_rd_if`, slave modport of `axi3_rd_if #(BUS_WIDTH)`, with these channels:
  - AR: `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arvalid`/`arready`.
  - R: `rid`, `rdata`, `rresp`, `rlast`, `rvalid`/`rready`.
- `line_recv`, out, `LINE_WIDTH`: last completed write line.
- `line_recv_vld`, out, 1: one-cycle pulse when a new line is available on `line_recv`.

## Operation
Write FSM has three states: W_IDLE → W_DATA → W_RESP → W_IDLE.
- W_IDLE:
  - `awready=1`.
  - On the AW handshake, latch `awid`, clear the beat index, clear the line register, go to W_DATA.
- W_DATA:
  - `wready=1`.
  - Each W handshake writes `wdata` into line bits `[32*idx+31:32*idx]`.
  - Bytes with `wstrb` bit 0 are stored as 0x00.
  - `idx` increments modulo `BEATS`, so over-length bursts wrap and overwrite.
  - The handshake carrying `wlast=1` completes the line and moves to W_RESP. `awlen` is not used for termination.
- W_RESP:
  - `bvalid=1`, `bid`=latched id, `bresp=OKAY` (2'b00).
  - On `bready` return to W_IDLE.
- `wid`, `awaddr`, `awsize` and `awburst` are ignored. Incrementing, line-aligned, 4-byte beats are implied.

Read FSM has two states: R_IDLE → R_DATA → R_IDLE.
- R_IDLE:
  - `arready=1`.
  - On the AR handshake, latch `arid`, `araddr` and `arlen`, set `cnt=0`.
- R_DATA:
  - `rvalid=1`, `rdata = araddr + 4*cnt` (truncated to `DATA_WIDTH`), `rid`=latched id, `rresp=OKAY`, `rlast = (cnt==arlen)`.
  - `cnt` advances on each R handshake.
  - The handshake with `rlast=1` returns to R_IDLE.

## Timing
- Reset values of all outputs are 0: `awready`, `wready`, `bvalid`, `bid`, `bresp`, `arready`, `rvalid`, `rid`, `rdata`, `rresp`, `rlast`, `line_recv`, `line_recv_vld`.
- The FSMs enter their IDLE states on the first clock after reset release.
- Assertion of reset mid-burst aborts both FSMs immediately. No B or R response is issued for the aborted burst.
- AW, W, B and AR, R ready/valid handshakes complete on a clock edge where both signals are 1.
- `line_recv` and `line_recv_vld`:
  - On the edge accepting the `wlast` beat, `line_recv` gets the completed line and `line_recv_vld` is 1 for exactly the following cycle.
  - `line_recv` then holds its value until the next completed burst.
- `bvalid` asserts the cycle after the `wlast` handshake and is held until `bready`.
- At most one write burst and one read burst are outstanding. AW/AR are not accepted again until the B/R phase ends.
- Write latency: a burst of N beats with continuous `wvalid` reaches `line_recv_vld` N+1 cycles after the AW handshake.
- Read latency: the first `rvalid` is the cycle after the AR handshake, and beats stream back-to-back while `rready=1`.
- If `rready=0`, all R outputs hold stable.
- Simultaneous read and write activity is fully independent.

## Configuration
- `IDENTITY_DEVICE_RD_EN` defined: the read FSM is compiled in as described above.
- Not defined: the read channel is tied off (`arready=0`, `rvalid=0`, `rlast=0`, `rid=0`, `rdata=0`, `rresp=0`). Write behaviour is unchanged.

## Test plan
- Write burst, `awid=1`, `awlen=7`, beats 0x00000000..0x00000007, `wstrb=4'hF` → one `line_recv_vld` pulse; `line_recv=256'h00000007_00000006_..._00000000`; `bid=1`, `bresp=0`.
- Two back-to-back line bursts with `bready` held 1 → two pulses, each line correct; second AW accepted only after the B handshake.
- Burst with `wstrb=4'h3` on beat 0 and data 0xDEADBEEF → low word of `line_recv` = 0x0000BEEF.
- Read `araddr=0x1000`, `arlen=7`, `rready` toggling 1/0 → `rdata` 0x1000, 0x1004, …, 0x101C; `rlast` only on the 8th beat; data stable while stalled.
- Reset asserted mid W_DATA after 3 beats → no pulse and no `bvalid`; all outputs 0; the next full burst completes normally.
- Without `IDENTITY_DEVICE_RD_EN`: AR asserted for 20 cycles → `arready` and `rvalid` stay 0; a concurrent write still pulses `line_recv_vld`.
